// File: rtl/game_tick_controller.sv
// game_tick_controller
//   Periodic tick source for the game loop. A 32-bit reload down-counter is
//   sequenced by an IDLE/RUN/PAUSED state machine. The tick period comes from
//   the difficulty level or from a software override. A new period is only
//   picked up at the next reload, so a tick interval is never cut short or
//   doubled.
//
// Ports
//   clock            system clock, rising edge
//   reset            synchronous, active-high reset
//   start            pulse: (re)start counting from a full period
//   pause_toggle     pulse: RUN <-> PAUSED
//   level_up         pulse: increment level (saturating), drop the override
//   override_valid   pulse: latch override_period as the period
//   override_period  requested period in cycles (0 is treated as 1)
//   tick             registered one-cycle pulse, once per period
//   running          high in RUN
//   paused           high in PAUSED
//   level            current difficulty level
//   period           effective period register
module game_tick_controller #(
  parameter int unsigned BASE_PERIOD = 50_000_000,
  parameter int unsigned PERIOD_STEP = 5_000_000,
  parameter int unsigned MIN_PERIOD  = 5_000_000,
  parameter int unsigned NUM_LEVELS  = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        pause_toggle,
  input  logic        level_up,
  input  logic        override_valid,
  input  logic [31:0] override_period,
  output logic        tick,
  output logic        running,
  output logic        paused,
  output logic [2:0]  level,
  output logic [31:0] period
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSED
  } state_e;

  localparam logic [2:0]  LEVEL_MAX    = 3'(NUM_LEVELS - 1);
  localparam logic [31:0] RESET_PERIOD = (BASE_PERIOD > MIN_PERIOD) ?
                                         32'(BASE_PERIOD) : 32'(MIN_PERIOD);

  state_e      state_q;
  logic [31:0] counter_q;
  logic        tick_q;
  logic        running_q;
  logic        paused_q;
  logic [2:0]  level_q,   level_d;
  logic        ovr_q,     ovr_d;
  logic [31:0] ovr_val_q, ovr_val_d;
  logic [31:0] period_q,  period_d;

  logic [32:0] lvl_prod;
  logic [32:0] lvl_diff;
  logic        count_zero;
  logic [31:0] reload_val;
  logic [31:0] counter_step;

  // Level / override bookkeeping and the period derived from their next state.
  always_comb begin
    level_d   = level_q;
    ovr_d     = ovr_q;
    ovr_val_d = ovr_val_q;
    if (level_up && (level_q < LEVEL_MAX)) begin
      level_d = level_q + 3'd1;
    end
    if (override_valid) begin
      ovr_d     = 1'b1;
      ovr_val_d = (override_period == '0) ? 32'd1 : override_period;
    end else if (level_up) begin
      ovr_d = 1'b0;
    end

    // 33-bit difference: bit 32 flags an underflow of the level formula.
    lvl_prod = 33'(level_d) * 33'(PERIOD_STEP);
    lvl_diff = 33'(BASE_PERIOD) - lvl_prod;
    if (ovr_d) begin
      period_d = ovr_val_d;
    end else if (lvl_diff[32] || (lvl_diff < 33'(MIN_PERIOD))) begin
      period_d = 32'(MIN_PERIOD);
    end else begin
      period_d = lvl_diff[31:0];
    end
  end

  // One countdown step; reload uses the period held before this edge.
  always_comb begin
    count_zero   = (counter_q == '0);
    reload_val   = period_q - 32'd1;
    counter_step = count_zero ? reload_val : (counter_q - 32'd1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      counter_q <= '0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
      level_q   <= '0;
      ovr_q     <= 1'b0;
      ovr_val_q <= '0;
      period_q  <= RESET_PERIOD;
    end else begin
      level_q   <= level_d;
      ovr_q     <= ovr_d;
      ovr_val_q <= ovr_val_d;
      period_q  <= period_d;
      tick_q    <= 1'b0;

      if (start) begin
        state_q   <= ST_RUN;
        running_q <= 1'b1;
        paused_q  <= 1'b0;
        counter_q <= reload_val;
      end else begin
        case (state_q)
          ST_IDLE: begin
            running_q <= 1'b0;
            paused_q  <= 1'b0;
          end
          ST_RUN: begin
            if (pause_toggle) begin
              // Counter held; a tick due at zero is deferred until resume.
              state_q   <= ST_PAUSED;
              running_q <= 1'b0;
              paused_q  <= 1'b1;
            end else begin
              tick_q    <= count_zero;
              counter_q <= counter_step;
            end
          end
          ST_PAUSED: begin
            if (pause_toggle) begin
              // The resume edge is itself a counting edge, so the interval
              // stretches by exactly the number of cycles spent paused.
              state_q   <= ST_RUN;
              running_q <= 1'b1;
              paused_q  <= 1'b0;
              tick_q    <= count_zero;
              counter_q <= counter_step;
            end
          end
          default: begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            paused_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tick    = tick_q;
  assign running = running_q;
  assign paused  = paused_q;
  assign level   = level_q;
  assign period  = period_q;

endmodule

// File: tb/tb_game_tick_controller.sv
module tb_game_tick_controller;

  localparam int BASE = 10;
  localparam int STEP = 2;
  localparam int MINP = 4;
  localparam int NLVL = 8;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSED = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        pause_toggle = 1'b0;
  logic        level_up = 1'b0;
  logic        override_valid = 1'b0;
  logic [31:0] override_period = '0;
  logic        tick;
  logic        running;
  logic        paused;
  logic [2:0]  level;
  logic [31:0] period;

  int checks = 0;
  int errors = 0;

  // Reference model: mode, RUN edges elapsed since the last reload, and the
  // period that reload was armed with.
  int m_mode   = M_IDLE;
  int m_n      = 0;
  int m_pr     = 1;
  bit m_tick   = 1'b0;
  int m_level  = 0;
  bit m_ovr    = 1'b0;
  int m_ovrval = 0;
  int m_period = BASE;

  always #5 clock = ~clock;

  game_tick_controller #(
    .BASE_PERIOD (BASE),
    .PERIOD_STEP (STEP),
    .MIN_PERIOD  (MINP),
    .NUM_LEVELS  (NLVL)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .pause_toggle    (pause_toggle),
    .level_up        (level_up),
    .override_valid  (override_valid),
    .override_period (override_period),
    .tick            (tick),
    .running         (running),
    .paused          (paused),
    .level           (level),
    .period          (period)
  );

  function automatic int model_period(input int lvl, input bit ovr, input int val);
    int p;
    if (ovr) return (val == 0) ? 1 : val;
    p = BASE - lvl * STEP;
    if (p < MINP) p = MINP;
    return p;
  endfunction

  task automatic model_count(input int old_p);
    if (m_n == m_pr - 1) begin
      m_tick = 1'b1;
      m_pr   = old_p;
      m_n    = 0;
    end else begin
      m_n++;
    end
  endtask

  task automatic model_edge();
    int old_p;
    if (reset) begin
      m_mode = M_IDLE; m_n = 0; m_pr = 1; m_tick = 1'b0;
      m_level = 0; m_ovr = 1'b0; m_ovrval = 0;
      m_period = model_period(0, 1'b0, 0);
      return;
    end
    old_p  = m_period;
    m_tick = 1'b0;
    if (start) begin
      m_mode = M_RUN; m_pr = old_p; m_n = 0;
    end else if (m_mode == M_RUN) begin
      if (pause_toggle) m_mode = M_PAUSED;
      else model_count(old_p);
    end else if (m_mode == M_PAUSED) begin
      if (pause_toggle) begin
        m_mode = M_RUN;
        model_count(old_p);
      end
    end
    if (level_up && m_level < NLVL - 1) m_level++;
    if (override_valid) begin
      m_ovr = 1'b1; m_ovrval = int'(override_period);
    end else if (level_up) begin
      m_ovr = 1'b0;
    end
    m_period = model_period(m_level, m_ovr, m_ovrval);
  endtask

  // One clock edge: update the model with the inputs seen at the edge,
  // settle, then drop all single-cycle pulses.
  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    reset = 1'b0; start = 1'b0; pause_toggle = 1'b0;
    level_up = 1'b0; override_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; step();
    checks++;
    if ({tick, running, paused} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {tick, running, paused});
    end
    checks++;
    if (level !== 3'd0) begin
      errors++; $display("FAIL reset_level: got %0d expected 0", level);
    end
    checks++;
    if (period !== 32'd10) begin
      errors++; $display("FAIL reset_period: got %0d expected 10", period);
    end
  endtask

  task automatic test_basic_ticks();
    reset = 1'b1; step();
    start = 1'b1; step();
    checks++;
    if (running !== 1'b1 || period !== 32'd10) begin
      errors++; $display("FAIL basic_run: running=%b period=%0d expected 1/10", running, period);
    end
    for (int c = 1; c <= 30; c++) begin
      step();
      checks++;
      if (tick !== (c % 10 == 0)) begin
        errors++; $display("FAIL basic_tick cycle %0d: got %b expected %b", c, tick, (c % 10 == 0));
      end
    end
  endtask

  task automatic test_levels();
    int exp_p[8] = '{10, 8, 6, 4, 4, 4, 4, 4};
    reset = 1'b1; step();
    for (int i = 1; i <= 7; i++) begin
      level_up = 1'b1; step();
      checks++;
      if (level !== 3'(i) || period !== 32'(exp_p[i])) begin
        errors++;
        $display("FAIL level_step %0d: level=%0d period=%0d expected %0d/%0d", i, level, period, i, exp_p[i]);
      end
    end
    level_up = 1'b1; step();
    checks++;
    if (level !== 3'd7 || period !== 32'd4) begin
      errors++; $display("FAIL level_saturate: level=%0d period=%0d expected 7/4", level, period);
    end
    start = 1'b1; step();
    for (int c = 1; c <= 12; c++) begin
      step();
      checks++;
      if (tick !== (c % 4 == 0)) begin
        errors++; $display("FAIL level_tick cycle %0d: got %b expected %b", c, tick, (c % 4 == 0));
      end
    end
  endtask

  task automatic test_level_at_reload();
    reset = 1'b1; step();
    start = 1'b1; step();
    for (int c = 1; c <= 30; c++) begin
      if (c == 10) level_up = 1'b1;
      step();
      checks++;
      if (tick !== (c == 10 || c == 20 || c == 28)) begin
        errors++; $display("FAIL reload_level_tick cycle %0d: got %b expected %b",
                           c, tick, (c == 10 || c == 20 || c == 28));
      end
    end
  endtask

  task automatic test_pause();
    logic exp_p;
    reset = 1'b1; step();
    start = 1'b1; step();
    for (int c = 1; c <= 30; c++) begin
      if (c == 13 || c == 20) pause_toggle = 1'b1;
      step();
      exp_p = (c >= 13 && c <= 19);
      checks++;
      if (tick !== (c == 10 || c == 27) || paused !== exp_p || running !== !exp_p) begin
        errors++; $display("FAIL pause cycle %0d: tick=%b paused=%b running=%b expected %b/%b/%b",
                           c, tick, paused, running, (c == 10 || c == 27), exp_p, !exp_p);
      end
    end
  endtask

  task automatic test_override();
    reset = 1'b1; step();
    start = 1'b1; step();
    for (int c = 1; c <= 24; c++) begin
      if (c == 3) begin override_valid = 1'b1; override_period = 32'd0; end
      if (c == 15) level_up = 1'b1;
      step();
      checks++;
      if (tick !== ((c >= 10 && c <= 16) || c == 24)) begin
        errors++; $display("FAIL override_tick cycle %0d: got %b expected %b",
                           c, tick, ((c >= 10 && c <= 16) || c == 24));
      end
      if (c == 3) begin
        checks++;
        if (period !== 32'd1) begin
          errors++; $display("FAIL override_zero_period: got %0d expected 1", period);
        end
      end
      if (c == 15) begin
        checks++;
        if (period !== 32'd8 || level !== 3'd1) begin
          errors++; $display("FAIL override_cleared: period=%0d level=%0d expected 8/1", period, level);
        end
      end
    end
  endtask

  task automatic test_start_pause_reset();
    reset = 1'b1; step();
    start = 1'b1; step();
    for (int c = 1; c <= 30; c++) begin
      if (c == 5) begin start = 1'b1; pause_toggle = 1'b1; end
      if (c == 8) level_up = 1'b1;
      if (c == 18) reset = 1'b1;
      step();
      if (c == 5) begin
        checks++;
        if (running !== 1'b1 || paused !== 1'b0) begin
          errors++; $display("FAIL start_beats_pause: running=%b paused=%b expected 1/0", running, paused);
        end
      end
      checks++;
      if (c < 18) begin
        if (tick !== (c == 15)) begin
          errors++; $display("FAIL restart_tick cycle %0d: got %b expected %b", c, tick, (c == 15));
        end
      end else begin
        if ({tick, running, paused, level} !== 6'b0 || period !== 32'd10) begin
          errors++; $display("FAIL reset_mid cycle %0d: flags=%b level=%0d period=%0d expected 000/0/10",
                             c, {tick, running, paused}, level, period);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [37:0] got, exp;
    reset = 1'b1; step();
    for (int c = 0; c < 4000; c++) begin
      reset          = ($urandom_range(0, 499) == 0);
      start          = ($urandom_range(0, 39) == 0);
      pause_toggle   = ($urandom_range(0, 14) == 0);
      level_up       = ($urandom_range(0, 59) == 0);
      override_valid = ($urandom_range(0, 49) == 0);
      if (override_valid) override_period = 32'($urandom_range(0, 12));
      step();
      got = {tick, running, paused, level, period};
      exp = {m_tick, (m_mode == M_RUN), (m_mode == M_PAUSED), 3'(m_level), 32'(m_period)};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL random cycle %0d: got %h expected %h", c, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_ticks();
    test_levels();
    test_level_at_reload();
    test_pause();
    test_override();
    test_start_pause_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
